piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port pi, input, WIDTH bits, the parallel word to transmit.
REQ-006 The block SHALL have port load, input, 1 bit, a request to accept pi.
REQ-007 The block SHALL have port ready, output, 1 bit, high when a load will be accepted this cycle.
REQ-008 The block SHALL have port so, output, 1 bit, the registered serial data bit.
REQ-009 The block SHALL have port so_valid, output, 1 bit, high while so carries a data bit.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse coincident with the last bit of a word.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and SHIFT, plus a shift register of WIDTH bits and a bit counter of ceil(log2(WIDTH)) bits.
REQ-012 ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when the counter is 0 (last bit on so); 0 otherwise.
REQ-013 A load SHALL be accepted on a rising edge where load=1 and ready=1; a load with ready=0 SHALL be ignored, with no effect on state or outputs.
REQ-014 On acceptance, the block SHALL register the first bit (pi[WIDTH-1] if MSB_FIRST=1, else pi[0]) onto so, assert so_valid, load the remaining bits, set the counter to WIDTH-1, and enter SHIFT; latency is 1 cycle, load edge to first bit.
REQ-015 In SHIFT with counter>0, each edge SHALL present the next bit in the selected order on so and decrement the counter.
REQ-016 Each data bit SHALL be held on so for exactly one clock cycle; a word occupies exactly WIDTH consecutive so_valid cycles.
REQ-017 done SHALL be 1 exactly in the cycle where the counter is 0 in SHIFT (last bit on so), and 0 otherwise.
REQ-018 In SHIFT with counter=0 and no accepted load, the next edge SHALL return to IDLE with so=0 and so_valid=0.
REQ-019 In SHIFT with counter=0 and an accepted load, the next edge SHALL start the new word (REQ-014) with no gap; so_valid stays 1 continuously.
REQ-020 While so_valid=0, so SHALL be driven 0.
REQ-021 pi SHALL be sampled only at the acceptance edge; later changes to pi SHALL NOT affect the word in flight.

Reset
REQ-022 While rst=1, the block SHALL asynchronously force state=IDLE, shift register=0, counter=0, so=0, so_valid=0, and done=0, independent of clk.
REQ-023 While rst=1, ready SHALL read 0 and load SHALL be ignored.
REQ-024 An assertion of rst mid-word SHALL abort the word with no partial completion; after release, ready=1 and the first accepted load starts a fresh word.

Verification
REQ-025 The bench SHALL check: WIDTH=4, MSB_FIRST=1, pi=4'b1011 loaded once -> so=1,0,1,1 on cycles 1-4 after the load edge, so_valid=1 on those cycles, done=1 only on cycle 4, then so=0 and so_valid=0.
REQ-026 The bench SHALL check: MSB_FIRST=0, pi=4'b1011 -> so=1,1,0,1, done on the 4th bit.
REQ-027 The bench SHALL check: back-to-back traffic, with 4'b1011 loaded, load held with pi=4'b0110 on the done cycle -> an 8-cycle unbroken so_valid stream 1,0,1,1,0,1,1,0 and two done pulses (cycles 4 and 8).
REQ-028 The bench SHALL check: load=1 with pi=4'b0000 asserted in bit cycles 1-3 of a 4'b1111 word -> ignored; so=1,1,1,1 then idle.
REQ-029 The bench SHALL check: rst pulsed asynchronously (between clk edges) during bit 2 of 4'b1011 -> so, so_valid, and done go 0 immediately; after release ready=1, and loading 4'b0101 yields 0,1,0,1.
REQ-030 The bench SHALL check: pi changed on every cycle during shifting of 4'b1001 -> output remains 1,0,0,1.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: a word accepted on load is shifted out one bit per clock,
// with so_valid framing, a done pulse on the last bit, and gapless back-to-back loading.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             load,
  output logic             ready,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] first_rest;
  logic             next_bit;
  logic [WIDTH-1:0] next_rest;

  // In IDLE the counter is held at 0, so one test covers both the idle and last-bit cases.
  assign ready  = !rst && ((state == IDLE) || (cnt == '0));
  assign accept = load && ready;

  always_comb begin
    if (MSB_FIRST != 0) begin
      first_bit  = pi[WIDTH-1];
      first_rest = {pi[WIDTH-2:0], 1'b0};
      next_bit   = sr[WIDTH-1];
      next_rest  = {sr[WIDTH-2:0], 1'b0};
    end else begin
      first_bit  = pi[0];
      first_rest = {1'b0, pi[WIDTH-1:1]};
      next_bit   = sr[0];
      next_rest  = {1'b0, sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state    <= SHIFT;
        so       <= first_bit;
        sr       <= first_rest;
        cnt      <= CW'(WIDTH - 1);
        so_valid <= 1'b1;
      end else if (state == SHIFT) begin
        if (cnt != '0) begin
          so   <= next_bit;
          sr   <= next_rest;
          cnt  <= cnt - 1'b1;
          done <= (cnt == CW'(1));
        end else begin
          state    <= IDLE;
          so       <= 1'b0;
          so_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first and an LSB-first instance share stimulus,
// and each step compares outputs against hand-computed bit sequences.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pi  = '0;
  logic       load = 1'b0;

  logic ready_m, so_m, sv_m, done_m;
  logic ready_l, so_l, sv_l, done_l;

  int checks   = 0;
  int failures = 0;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .pi(pi), .load(load),
    .ready(ready_m), .so(so_m), .so_valid(sv_m), .done(done_m)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .pi(pi), .load(load),
    .ready(ready_l), .so(so_l), .so_valid(sv_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_m(input string tag, input logic s, input logic v, input logic d);
    check({tag, "_so"}, {31'b0, so_m}, {31'b0, s});
    check({tag, "_valid"}, {31'b0, sv_m}, {31'b0, v});
    check({tag, "_done"}, {31'b0, done_m}, {31'b0, d});
  endtask

  task automatic exp_l(input string tag, input logic s, input logic v, input logic d);
    check({tag, "_so_l"}, {31'b0, so_l}, {31'b0, s});
    check({tag, "_valid_l"}, {31'b0, sv_l}, {31'b0, v});
    check({tag, "_done_l"}, {31'b0, done_l}, {31'b0, d});
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    #3;
    exp_m("rst", 1'b0, 1'b0, 1'b0);
    check("rst_ready", {31'b0, ready_m}, 32'd0);
    load = 1'b1;
    pi   = 4'b1111;
    tick();
    exp_m("rst_load_ignored", 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    rst  = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, ready_m}, 32'd1);
    tick();
    exp_m("idle", 1'b0, 1'b0, 1'b0);

    // single word 1011, both orders
    pi = 4'b1011; load = 1'b1;
    tick();
    load = 1'b0;
    exp_m("w1_b1", 1'b1, 1'b1, 1'b0); exp_l("w1_b1", 1'b1, 1'b1, 1'b0);
    check("w1_b1_ready", {31'b0, ready_m}, 32'd0);
    tick();
    exp_m("w1_b2", 1'b0, 1'b1, 1'b0); exp_l("w1_b2", 1'b1, 1'b1, 1'b0);
    tick();
    exp_m("w1_b3", 1'b1, 1'b1, 1'b0); exp_l("w1_b3", 1'b0, 1'b1, 1'b0);
    tick();
    exp_m("w1_b4", 1'b1, 1'b1, 1'b1); exp_l("w1_b4", 1'b1, 1'b1, 1'b1);
    check("w1_b4_ready", {31'b0, ready_m}, 32'd1);
    tick();
    exp_m("w1_idle", 1'b0, 1'b0, 1'b0); exp_l("w1_idle", 1'b0, 1'b0, 1'b0);
    check("w1_idle_ready", {31'b0, ready_m}, 32'd1);

    // back-to-back 1011 then 0110 loaded on the done cycle
    pi = 4'b1011; load = 1'b1;
    tick();
    load = 1'b0;
    exp_m("bb_b1", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("bb_b2", 1'b0, 1'b1, 1'b0);
    tick(); exp_m("bb_b3", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("bb_b4", 1'b1, 1'b1, 1'b1);
    pi = 4'b0110; load = 1'b1;
    tick();
    load = 1'b0;
    exp_m("bb_b5", 1'b0, 1'b1, 1'b0);
    tick(); exp_m("bb_b6", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("bb_b7", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("bb_b8", 1'b0, 1'b1, 1'b1);
    tick(); exp_m("bb_idle", 1'b0, 1'b0, 1'b0);

    // loads while busy are ignored
    pi = 4'b1111; load = 1'b1;
    tick();
    pi = 4'b0000;
    exp_m("ign_b1", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("ign_b2", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("ign_b3", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("ign_b4", 1'b1, 1'b1, 1'b1);
    load = 1'b0;
    tick(); exp_m("ign_idle", 1'b0, 1'b0, 1'b0);

    // asynchronous reset pulse during bit 2
    pi = 4'b1011; load = 1'b1;
    tick();
    load = 1'b0;
    exp_m("ar_b1", 1'b1, 1'b1, 1'b0);
    tick();
    exp_l("ar_b2", 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_m("ar_in_rst", 1'b0, 1'b0, 1'b0);
    exp_l("ar_in_rst", 1'b0, 1'b0, 1'b0);
    check("ar_in_rst_ready", {31'b0, ready_m}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("ar_post_ready", {31'b0, ready_m}, 32'd1);
    tick();
    exp_m("ar_no_resume", 1'b0, 1'b0, 1'b0);
    pi = 4'b0101; load = 1'b1;
    tick();
    load = 1'b0;
    exp_m("ar2_b1", 1'b0, 1'b1, 1'b0);
    tick(); exp_m("ar2_b2", 1'b1, 1'b1, 1'b0);
    tick(); exp_m("ar2_b3", 1'b0, 1'b1, 1'b0);
    tick(); exp_m("ar2_b4", 1'b1, 1'b1, 1'b1);
    tick(); exp_m("ar2_idle", 1'b0, 1'b0, 1'b0);

    // pi changes every cycle while shifting 1001
    pi = 4'b1001; load = 1'b1;
    tick();
    load = 1'b0;
    pi = 4'b0110;
    exp_m("pc_b1", 1'b1, 1'b1, 1'b0);
    tick(); pi = 4'b1111; exp_m("pc_b2", 1'b0, 1'b1, 1'b0);
    tick(); pi = 4'b0000; exp_m("pc_b3", 1'b0, 1'b1, 1'b0);
    tick(); pi = 4'b1010; exp_m("pc_b4", 1'b1, 1'b1, 1'b1);
    tick(); exp_m("pc_idle", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
